// File: rtl/ws_readout_arb.sv
// Readout arbiter that collects one-shot measurement words from several channels,
// timestamps them, and serialises them through a valid/ready port in round-robin order.
module ws_readout_arb #(
  parameter int NCH = 4,
  parameter int NW  = 16,
  parameter int NC  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ch_rdy,
  input  logic [NCH*NW-1:0] ch_data,
  input  logic [NC-1:0]     p_cnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_ch,
  output logic [NW-1:0]     out_data,
  output logic [NC-1:0]     out_pcnt,
  output logic [NCH-1:0]    ovf,
  input  logic              clr_ovf
);

  localparam int CW = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_last_grant;
  logic            r_out_valid;
  logic [CW-1:0]   r_out_ch;
  logic [NW-1:0]   r_out_data;
  logic [NC-1:0]   r_out_pcnt;

  logic [NW-1:0]   w_data [NCH];
  logic [NC-1:0]   w_ts   [NCH];
  logic [NCH-1:0]  w_pend;
  logic            w_any;
  logic [CW-1:0]   w_grant_idx;
  logic            w_grant_en;

  // Scan from the farthest candidate back to last_grant+1 so the nearest pending one wins.
  always_comb begin
    w_any       = 1'b0;
    w_grant_idx = r_last_grant;
    for (int k = NCH; k >= 1; k--) begin
      if (w_pend[r_last_grant + CW'(k)]) begin
        w_any       = 1'b1;
        w_grant_idx = r_last_grant + CW'(k);
      end
    end
  end

  assign w_grant_en = (r_state == IDLE) && w_any;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_slot
      logic [NW-1:0] r_data;
      logic [NC-1:0] r_ts;
      logic          r_pend;
      logic          r_ovf;
      logic          w_hit;

      assign w_hit = w_grant_en && (w_grant_idx == CW'(gi));

      // A word arriving on the grant edge refills the slot being emptied instead of overflowing.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data <= '0;
          r_ts   <= '0;
          r_pend <= 1'b0;
          r_ovf  <= 1'b0;
        end else begin
          if (ch_rdy[gi] && (!r_pend || w_hit)) begin
            r_data <= ch_data[gi*NW +: NW];
            r_ts   <= p_cnt;
            r_pend <= 1'b1;
          end else if (w_hit) begin
            r_pend <= 1'b0;
          end
          if (ch_rdy[gi] && r_pend && !w_hit) begin
            r_ovf <= 1'b1;
          end else if (clr_ovf) begin
            r_ovf <= 1'b0;
          end
        end
      end

      assign w_data[gi] = r_data;
      assign w_ts[gi]   = r_ts;
      assign w_pend[gi] = r_pend;
      assign ovf[gi]    = r_ovf;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= CW'(NCH - 1);
      r_out_valid  <= 1'b0;
      r_out_ch     <= '0;
      r_out_data   <= '0;
      r_out_pcnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_en) begin
            r_out_ch     <= w_grant_idx;
            r_out_data   <= w_data[w_grant_idx];
            r_out_pcnt   <= w_ts[w_grant_idx];
            r_out_valid  <= 1'b1;
            r_last_grant <= w_grant_idx;
            r_state      <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out_data  = r_out_data;
  assign out_pcnt  = r_out_pcnt;

endmodule

// File: tb/tb_ws_readout_arb.sv
// Directed bench for ws_readout_arb: stimulus pushes expected records into a queue and a
// negedge monitor pops/compares every accepted record; direct checks cover timing and flags.
module tb_ws_readout_arb;

  localparam int NCH = 4;
  localparam int NW  = 16;
  localparam int NC  = 32;

  typedef struct packed {
    logic [1:0]    ch;
    logic [NW-1:0] data;
    logic [NC-1:0] pcnt;
  } rec_t;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    ch_rdy;
  logic [NCH*NW-1:0] ch_data;
  logic [NC-1:0]     p_cnt;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_ch;
  logic [NW-1:0]     out_data;
  logic [NC-1:0]     out_pcnt;
  logic [NCH-1:0]    ovf;
  logic              clr_ovf;

  rec_t exp_q[$];
  int   total;
  int   bad;

  ws_readout_arb #(.NCH(NCH), .NW(NW), .NC(NC)) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_rdy    (ch_rdy),
    .ch_data   (ch_data),
    .p_cnt     (p_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .out_pcnt  (out_pcnt),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: act=0x%0h req=0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_word(input int ch, input logic [NW-1:0] w);
    ch_data[ch*NW +: NW] = w;
  endtask

  task automatic push(input logic [1:0] ch, input logic [NW-1:0] d, input logic [NC-1:0] p);
    rec_t r;
    r.ch   = ch;
    r.data = d;
    r.pcnt = p;
    exp_q.push_back(r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid_immediate", 64'(out_valid), 64'd0);
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    step();
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: one line per accepted record.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      rec_t r;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rec_unexpected: act ch=%0d data=0x%0h pcnt=%0d req=none", out_ch, out_data, out_pcnt);
      end else begin
        r = exp_q.pop_front();
        if (out_ch !== r.ch || out_data !== r.data || out_pcnt !== r.pcnt) begin
          bad++;
          $display("FAIL rec: act ch=%0d data=0x%0h pcnt=%0d req ch=%0d data=0x%0h pcnt=%0d",
                   out_ch, out_data, out_pcnt, r.ch, r.data, r.pcnt);
        end else begin
          $display("rec  ch=%0d data=0x%0h pcnt=%0d", out_ch, out_data, out_pcnt);
        end
      end
    end
  end

  initial begin
    int cnt;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    ch_rdy    = '0;
    ch_data   = '0;
    p_cnt     = '0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;

    step();
    step();
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_ch",    64'(out_ch),    64'd0);
    check("reset_data",  64'(out_data),  64'd0);
    check("reset_pcnt",  64'(out_pcnt),  64'd0);
    check("reset_ovf",   64'(ovf),       64'd0);
    rst = 1'b0;
    step();
    step();
    check("idle_no_valid", 64'(out_valid), 64'd0);

    // Single strobe: valid two cycles later, held one cycle.
    out_ready = 1'b1;
    set_word(2, 16'h1234);
    p_cnt  = 32'd7;
    ch_rdy = 4'b0100;
    push(2'd2, 16'h1234, 32'd7);
    step();
    ch_rdy = '0;
    sample();
    check("lat_t1_valid", 64'(out_valid), 64'd0);
    step();
    sample();
    check("lat_t2_valid", 64'(out_valid), 64'd1);
    step();
    sample();
    check("lat_t3_valid", 64'(out_valid), 64'd0);
    check("lat_ovf", 64'(ovf), 64'd0);
    drain("single_drain");

    // All four channels at once after reset: ch0..ch3, every other cycle.
    do_reset();
    for (int i = 0; i < NCH; i++) begin
      set_word(i, 16'hA000 + 16'(i));
      push(2'(i), 16'hA000 + 16'(i), 32'd20);
    end
    p_cnt  = 32'd20;
    ch_rdy = 4'hF;
    step();
    ch_rdy = '0;
    for (int c = 1; c <= 8; c++) begin
      step();
      sample();
      check($sformatf("rr_valid_c%0d", c), 64'(out_valid), 64'(c % 2));
    end
    check("rr_ovf", 64'(ovf), 64'd0);
    drain("rr_drain");

    // Stalled output: second strobe into a full slot overflows and is dropped.
    do_reset();
    out_ready = 1'b0;
    set_word(1, 16'h1111);
    p_cnt  = 32'd30;
    ch_rdy = 4'b0010;
    push(2'd1, 16'h1111, 32'd30);
    step();
    ch_rdy = '0;
    step();
    set_word(1, 16'hAAAA);
    p_cnt  = 32'd31;
    ch_rdy = 4'b0010;
    push(2'd1, 16'hAAAA, 32'd31);
    step();
    ch_rdy = '0;
    step();
    sample();
    check("stall_ovf_before", 64'(ovf), 64'd0);
    set_word(1, 16'hBBBB);
    p_cnt  = 32'd33;
    ch_rdy = 4'b0010;
    step();
    ch_rdy = '0;
    sample();
    check("stall_ovf_after", 64'(ovf), 64'b0010);
    check("stall_hold_data", 64'(out_data), 64'h1111);
    check("stall_hold_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    drain("stall_drain");

    // Strobe on the grant edge of the same channel refills the slot without overflow.
    do_reset();
    out_ready = 1'b1;
    set_word(3, 16'hC001);
    p_cnt  = 32'd40;
    ch_rdy = 4'b1000;
    push(2'd3, 16'hC001, 32'd40);
    step();
    set_word(3, 16'hC002);
    p_cnt  = 32'd41;
    push(2'd3, 16'hC002, 32'd41);
    step();
    ch_rdy = '0;
    sample();
    check("regrant_data", 64'(out_data), 64'hC001);
    check("regrant_ovf", 64'(ovf), 64'd0);
    drain("regrant_drain");
    check("regrant_ovf_end", 64'(ovf), 64'd0);

    // Overflow coinciding with clr_ovf: set wins; clr_ovf alone clears.
    do_reset();
    out_ready = 1'b0;
    set_word(0, 16'hD001);
    p_cnt  = 32'd50;
    ch_rdy = 4'b0001;
    push(2'd0, 16'hD001, 32'd50);
    step();
    ch_rdy = '0;
    step();
    set_word(0, 16'hD002);
    p_cnt  = 32'd51;
    ch_rdy = 4'b0001;
    push(2'd0, 16'hD002, 32'd51);
    step();
    set_word(0, 16'hD003);
    p_cnt   = 32'd52;
    clr_ovf = 1'b1;
    step();
    ch_rdy = '0;
    sample();
    check("clr_set_wins", 64'(ovf), 64'b0001);
    step();
    clr_ovf = 1'b0;
    sample();
    check("clr_alone", 64'(ovf), 64'd0);
    out_ready = 1'b1;
    drain("clr_drain");

    // Reset in flight with two channels still pending.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) set_word(i, 16'hE000 + 16'(i));
    p_cnt  = 32'd60;
    ch_rdy = 4'b0111;
    step();
    ch_rdy = '0;
    step();
    sample();
    check("midrst_valid_before", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_valid_now", 64'(out_valid), 64'd0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      sample();
      if (out_valid) cnt++;
    end
    check("midrst_no_records", 64'(cnt), 64'd0);
    set_word(3, 16'hF003);
    p_cnt  = 32'hFFFF_FFFF;
    ch_rdy = 4'b1000;
    push(2'd3, 16'hF003, 32'hFFFF_FFFF);
    step();
    ch_rdy = '0;
    drain("midrst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
